// File: rtl/adder_sum_accumulator.sv
// Accumulates BATCH adder sums per result and presents the total on a valid/ready port.
// Build option: define ACC_SAT_EN to saturate the total on overflow instead of wrapping.
module adder_sum_accumulator #(
  parameter int unsigned N     = 4,
  parameter int unsigned BATCH = 16,
  parameter int unsigned ACC_W = 8,
  localparam int unsigned CW   = $clog2(BATCH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N:0]       sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [CW-1:0]    count,
  output logic             ovf
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W:0]     add_sum;
  logic               beat;
  logic               last_beat;

  assign sum_ready = (state_q != StDone) && !rst;
  assign acc_valid = (state_q == StDone);
  assign acc_out   = acc_q;
  assign count     = count_q;
  assign ovf       = ovf_q;

  assign beat      = sum_valid && sum_ready;
  // Extra top bit captures the carry-out that flags overflow.
  assign add_sum   = {1'b0, acc_q} + (ACC_W + 1)'(sum_in);
  assign last_beat = (count_q + CW'(1)) == CW'(BATCH);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (beat) begin
            acc_d   = ACC_W'(sum_in);
            count_d = CW'(1);
            ovf_d   = 1'b0;
            state_d = (BATCH == 1) ? StDone : StAccum;
          end
        end
        StAccum: begin
          if (beat) begin
            count_d = count_q + CW'(1);
            if (add_sum[ACC_W]) ovf_d = 1'b1;
`ifdef ACC_SAT_EN
            // Once clamped, the total stays pinned for the rest of the batch.
            acc_d = (ovf_q || add_sum[ACC_W]) ? '1 : add_sum[ACC_W-1:0];
`else
            acc_d = add_sum[ACC_W-1:0];
`endif
            if (last_beat) state_d = StDone;
          end
        end
        StDone: begin
          if (acc_ready) begin
            state_d = StIdle;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed and table-driven bench for adder_sum_accumulator (default parameters).
// Expected values follow ACC_SAT_EN when it is defined for the build.
module tb_adder_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sum_in;
  logic       sum_valid;
  logic       sum_ready;
  logic       clear;
  logic [7:0] acc_out;
  logic       acc_valid;
  logic       acc_ready;
  logic [4:0] count;
  logic       ovf;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] sum;
    logic [7:0] exp_acc;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [6];

  adder_sum_accumulator #(.N(4), .BATCH(16), .ACC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .clear     (clear),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives n back-to-back beats; returns at the negedge after the last accepting edge.
  task automatic beats(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("count_during_batch", count, i);
      check("no_valid_during_batch", acc_valid, 0);
      sum_in    = v;
      sum_valid = 1'b1;
    end
    @(negedge clk);
    sum_valid = 1'b0;
  endtask

  task automatic done_check(input logic [7:0] exp_acc, input logic exp_ovf);
    check("acc_valid_done", acc_valid, 1);
    check("sum_ready_done", sum_ready, 0);
    check("count_done", count, 16);
    check("acc_out_done", acc_out, exp_acc);
    check("ovf_done", ovf, exp_ovf);
  endtask

  // Accepts the result while offering a beat that must be ignored.
  task automatic release_done(input logic [7:0] exp_acc);
    acc_ready = 1'b1;
    sum_valid = 1'b1;
    sum_in    = 5'd9;
    @(negedge clk);
    acc_ready = 1'b0;
    sum_valid = 1'b0;
    check("acc_valid_released", acc_valid, 0);
    check("count_released", count, 0);
    check("ovf_released", ovf, 0);
    check("acc_out_retained", acc_out, exp_acc);
    check("sum_ready_idle", sum_ready, 1);
  endtask

  initial begin
    int unsigned total;
    int          got;
    int          guard;
    logic        v_ok;
    logic [4:0]  v;
    logic [7:0]  exp_acc;

    vecs[0] = '{sum: 5'd1,  exp_acc: 8'd16,  exp_ovf: 1'b0};
    vecs[2] = '{sum: 5'd0,  exp_acc: 8'd0,   exp_ovf: 1'b0};
    vecs[3] = '{sum: 5'd15, exp_acc: 8'd240, exp_ovf: 1'b0};
`ifdef ACC_SAT_EN
    vecs[1] = '{sum: 5'd30, exp_acc: 8'd255, exp_ovf: 1'b1};
    vecs[4] = '{sum: 5'd16, exp_acc: 8'd255, exp_ovf: 1'b1};
    vecs[5] = '{sum: 5'd17, exp_acc: 8'd255, exp_ovf: 1'b1};
`else
    vecs[1] = '{sum: 5'd30, exp_acc: 8'd224, exp_ovf: 1'b1};
    vecs[4] = '{sum: 5'd16, exp_acc: 8'd0,   exp_ovf: 1'b1};
    vecs[5] = '{sum: 5'd17, exp_acc: 8'd16,  exp_ovf: 1'b1};
`endif

    rst       = 1'b1;
    sum_in    = '0;
    sum_valid = 1'b0;
    clear     = 1'b0;
    acc_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_acc_out", acc_out, 0);
    check("reset_acc_valid", acc_valid, 0);
    check("reset_count", count, 0);
    check("reset_ovf", ovf, 0);
    check("reset_sum_ready", sum_ready, 1);

    // Full batches of a constant sum.
    for (int k = 0; k < 6; k++) begin
      beats(vecs[k].sum, 16);
      done_check(vecs[k].exp_acc, vecs[k].exp_ovf);
      release_done(vecs[k].exp_acc);
    end

    // Back-pressure: result held stable for 5 cycles, incoming beats refused.
    beats(5'd1, 16);
    for (int k = 0; k < 5; k++) begin
      sum_valid = 1'b1;
      sum_in    = 5'd5;
      @(negedge clk);
      check("hold_acc_valid", acc_valid, 1);
      check("hold_sum_ready", sum_ready, 0);
      check("hold_acc_out", acc_out, 16);
    end
    sum_valid = 1'b0;
    done_check(8'd16, 1'b0);
    release_done(8'd16);

    // Clear mid-batch, with a simultaneous beat that must be dropped.
    beats(5'd7, 3);
    check("count_before_clear", count, 3);
    check("acc_before_clear", acc_out, 21);
    clear     = 1'b1;
    sum_valid = 1'b1;
    sum_in    = 5'd7;
    @(negedge clk);
    clear     = 1'b0;
    sum_valid = 1'b0;
    check("count_after_clear", count, 0);
    check("acc_after_clear", acc_out, 0);
    check("valid_after_clear", acc_valid, 0);
    beats(5'd2, 16);
    done_check(8'd32, 1'b0);
    release_done(8'd32);

    // Clear in DONE overrides a simultaneous acc_ready.
    beats(5'd30, 16);
    clear     = 1'b1;
    acc_ready = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    acc_ready = 1'b0;
    check("clear_done_valid", acc_valid, 0);
    check("clear_done_acc", acc_out, 0);
    check("clear_done_ovf", ovf, 0);
    check("clear_done_count", count, 0);

    // Asynchronous reset mid-batch and in DONE.
    beats(5'd3, 5);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_count", count, 0);
    check("rst_mid_valid", acc_valid, 0);
    check("rst_mid_acc", acc_out, 0);
    @(negedge clk);
    rst = 1'b0;
    beats(5'd1, 16);
    done_check(8'd16, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_done_valid", acc_valid, 0);
    check("rst_done_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    beats(5'd3, 16);
    done_check(8'd48, 1'b0);
    release_done(8'd48);

    // Random sums with random valid gaps and random result back-pressure.
    for (int b = 0; b < 20; b++) begin
      total = 0;
      got   = 0;
      guard = 0;
      while (got < 16 && guard < 400) begin
        @(negedge clk);
        v    = 5'($urandom_range(0, 30));
        v_ok = ($urandom_range(0, 3) != 0);
        sum_in    = v;
        sum_valid = v_ok;
        if (v_ok) begin
          total += v;
          got++;
        end
        guard++;
      end
      @(negedge clk);
      sum_valid = 1'b0;
      check("rand_beats_sent", got, 16);
`ifdef ACC_SAT_EN
      exp_acc = (total > 255) ? 8'd255 : 8'(total);
`else
      exp_acc = 8'(total % 256);
`endif
      done_check(exp_acc, total > 255);
      for (int d = 0; d < int'($urandom_range(0, 2)); d++) begin
        @(negedge clk);
      end
      release_done(exp_acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
